// File: rtl/collision_pkg.sv
// Shared types for the missile collision arbiter: FSM state and pixel coordinate.
package collision_pkg;
  localparam int COORD_W = 11;

  typedef enum logic [0:0] {ARMED, COOLDOWN} arb_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pix_coord_t;
endpackage

// File: rtl/missile_collision_arbiter_if.sv
// Drawing-request bus into the arbiter and collision/event results out of it.
interface missile_collision_arbiter_if #(parameter int CNT_W = 16);
  import collision_pkg::*;

  logic               startOfFrame;
  logic [COORD_W-1:0] pixelX;
  logic [COORD_W-1:0] pixelY;
  logic               missileDR;
  logic               monsterDR;
  logic               shieldDR;
  logic               borderDR;
  logic               collisionMonster;
  logic               collisionShield;
  logic               collisionBorder;
  logic               monsterHitEvent;
  logic               shieldHitEvent;
  logic [COORD_W-1:0] hitX;
  logic [COORD_W-1:0] hitY;
  logic [CNT_W-1:0]   monsterHitCount;
  logic [CNT_W-1:0]   missCount;

  modport master (
    output startOfFrame, pixelX, pixelY, missileDR, monsterDR, shieldDR, borderDR,
    input  collisionMonster, collisionShield, collisionBorder,
           monsterHitEvent, shieldHitEvent, hitX, hitY, monsterHitCount, missCount
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, missileDR, monsterDR, shieldDR, borderDR,
    output collisionMonster, collisionShield, collisionBorder,
           monsterHitEvent, shieldHitEvent, hitX, hitY, monsterHitCount, missCount
  );
endinterface

// File: rtl/missile_collision_arbiter_latch.sv
// Per-object-class frame flag: sticky "seen" plus coordinates of the first overlap.
module frame_hit_latch
  import collision_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       hit,
  input  pix_coord_t pix,
  output logic       seen,
  output pix_coord_t first
);
  // An overlap on the startOfFrame cycle already belongs to the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      seen  <= 1'b0;
      first <= '0;
    end else if (startOfFrame) begin
      seen <= hit;
      if (hit) first <= pix;
    end else if (hit && !seen) begin
      seen  <= 1'b1;
      first <= pix;
    end
  end
endmodule

// File: rtl/missile_collision_arbiter.sv
// Missile collision arbiter: registered per-pixel strobes plus per-frame
// monster/shield event condensing with hold-off and saturating counters.
module missile_collision_arbiter
  import collision_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 2,
  parameter int CNT_W          = 16
)(
  input logic clk,
  input logic resetN,
  missile_collision_arbiter_if.slave bus
);
  localparam int NUM_CLS = 3;
  localparam int MON = 0, SHD = 1, BRD = 2;
  localparam int HO_W = $clog2(HOLDOFF_FRAMES + 2);

  logic                     sof;
  logic [NUM_CLS-1:0]       ovl, seen, coll_q;
  pix_coord_t               pix;
  pix_coord_t [NUM_CLS-1:0] first_pix;

  assign sof = bus.startOfFrame;
  assign pix = {bus.pixelX, bus.pixelY};
  assign ovl = {bus.missileDR & bus.borderDR,
                bus.missileDR & bus.shieldDR,
                bus.missileDR & bus.monsterDR};

  for (genvar i = 0; i < NUM_CLS; i++) begin : g_cls
    frame_hit_latch u_latch (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (sof),
      .hit          (ovl[i]),
      .pix          (pix),
      .seen         (seen[i]),
      .first        (first_pix[i])
    );
  end

  // Only the monster class reports coordinates.
  logic [2*$bits(pix_coord_t)-1:0] unused_coords;
  assign unused_coords = first_pix[BRD:SHD];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) coll_q <= '0;
    else         coll_q <= ovl;
  end

  // FSM: state register / next-state / outputs
  arb_state_t      state, state_nxt;
  logic [HO_W-1:0] ho_cnt, ho_nxt;
  logic            mon_evt, shd_evt, miss_inc;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= ARMED;
      ho_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ho_cnt <= ho_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ho_nxt    = ho_cnt;
    if (sof) begin
      case (state)
        ARMED: if (seen[MON]) begin
          ho_nxt = HO_W'(HOLDOFF_FRAMES);
          if (HOLDOFF_FRAMES > 0) state_nxt = COOLDOWN;
        end
        COOLDOWN: begin
          ho_nxt = (ho_cnt == '0) ? '0 : ho_cnt - 1'b1;
          if (ho_cnt <= HO_W'(1)) state_nxt = ARMED;
        end
        default: state_nxt = ARMED;
      endcase
    end
  end

  always_comb begin
    mon_evt  = sof && (state == ARMED) && seen[MON];
    shd_evt  = sof && seen[SHD] && !mon_evt;
    miss_inc = sof && seen[BRD];
  end

  logic                     mon_evt_q, shd_evt_q;
  logic [COORD_W-1:0]       hit_x_q, hit_y_q;
  logic [CNT_W-1:0]         mon_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mon_evt_q  <= 1'b0;
      shd_evt_q  <= 1'b0;
      hit_x_q    <= '0;
      hit_y_q    <= '0;
      mon_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      mon_evt_q <= mon_evt;
      shd_evt_q <= shd_evt;
      if (mon_evt) begin
        hit_x_q <= first_pix[MON].x;
        hit_y_q <= first_pix[MON].y;
        if (!(&mon_cnt_q)) mon_cnt_q <= mon_cnt_q + 1'b1;
      end
      if (miss_inc && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign bus.collisionMonster = coll_q[MON];
  assign bus.collisionShield  = coll_q[SHD];
  assign bus.collisionBorder  = coll_q[BRD];
  assign bus.monsterHitEvent  = mon_evt_q;
  assign bus.shieldHitEvent   = shd_evt_q;
  assign bus.hitX             = hit_x_q;
  assign bus.hitY             = hit_y_q;
  assign bus.monsterHitCount  = mon_cnt_q;
  assign bus.missCount        = miss_cnt_q;
endmodule

// File: tb/tb_missile_collision_arbiter.sv
// Directed bench for missile_collision_arbiter (HOLDOFF_FRAMES=2, CNT_W=2).
module tb_missile_collision_arbiter;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  missile_collision_arbiter_if #(.CNT_W(2)) bus();

  missile_collision_arbiter #(.HOLDOFF_FRAMES(2), .CNT_W(2)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic sof, input int x, input int y,
                       input logic mis, input logic mon, input logic shd, input logic bdr);
    bus.startOfFrame = sof;
    bus.pixelX       = 11'(x);
    bus.pixelY       = 11'(y);
    bus.missileDR    = mis;
    bus.monsterDR    = mon;
    bus.shieldDR     = shd;
    bus.borderDR     = bdr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sof_step();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.pixelX = '0; bus.pixelY = '0;
    bus.missileDR = 1'b0; bus.monsterDR = 1'b0;
    bus.shieldDR = 1'b0;  bus.borderDR = 1'b0;
    @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_collM"}, 32'(bus.collisionMonster), 0);
    chk({tag, "_collS"}, 32'(bus.collisionShield), 0);
    chk({tag, "_collB"}, 32'(bus.collisionBorder), 0);
    chk({tag, "_monEv"}, 32'(bus.monsterHitEvent), 0);
    chk({tag, "_shdEv"}, 32'(bus.shieldHitEvent), 0);
    chk({tag, "_hitX"},  32'(bus.hitX), 0);
    chk({tag, "_hitY"},  32'(bus.hitY), 0);
    chk({tag, "_monCnt"}, 32'(bus.monsterHitCount), 0);
    chk({tag, "_missCnt"}, 32'(bus.missCount), 0);
  endtask

  initial begin
    do_reset();
    chk_all_zero("rst");

    // single overlap followed by a second one in the same frame
    drive(1'b0, 100, 200, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("single_collM", 32'(bus.collisionMonster), 1);
    chk("single_collS", 32'(bus.collisionShield), 0);
    drive(1'b0, 140, 210, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("single_collM_off", 32'(bus.collisionMonster), 0);
    chk("single_noEvMid", 32'(bus.monsterHitEvent), 0);
    sof_step();
    chk("single_monEv", 32'(bus.monsterHitEvent), 1);
    chk("single_hitX", 32'(bus.hitX), 100);
    chk("single_hitY", 32'(bus.hitY), 200);
    chk("single_cnt", 32'(bus.monsterHitCount), 1);
    idle();
    chk("single_pulse1", 32'(bus.monsterHitEvent), 0);
    chk("single_hold", 32'(bus.hitX), 100);

    // hold-off: hits in frames 1..4 -> events after frames 1 and 4
    do_reset();
    drive(1'b0, 10, 20, 1'b1, 1'b1, 1'b0, 1'b0); sof_step();
    chk("ho_f1_ev", 32'(bus.monsterHitEvent), 1);
    chk("ho_f1_x", 32'(bus.hitX), 10);
    drive(1'b0, 30, 40, 1'b1, 1'b1, 1'b0, 1'b0); sof_step();
    chk("ho_f2_ev", 32'(bus.monsterHitEvent), 0);
    chk("ho_f2_x", 32'(bus.hitX), 10);
    drive(1'b0, 31, 41, 1'b1, 1'b1, 1'b0, 1'b0); sof_step();
    chk("ho_f3_ev", 32'(bus.monsterHitEvent), 0);
    drive(1'b0, 50, 60, 1'b1, 1'b1, 1'b0, 1'b0); sof_step();
    chk("ho_f4_ev", 32'(bus.monsterHitEvent), 1);
    chk("ho_f4_x", 32'(bus.hitX), 50);
    chk("ho_f4_y", 32'(bus.hitY), 60);
    chk("ho_cnt", 32'(bus.monsterHitCount), 2);

    // priority: monster beats shield; shield still reported during cooldown
    do_reset();
    drive(1'b0, 5, 6, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pri_collM", 32'(bus.collisionMonster), 1);
    chk("pri_collS", 32'(bus.collisionShield), 1);
    sof_step();
    chk("pri_monEv", 32'(bus.monsterHitEvent), 1);
    chk("pri_shdEv", 32'(bus.shieldHitEvent), 0);
    drive(1'b0, 7, 8, 1'b1, 1'b0, 1'b1, 1'b0); sof_step();
    chk("cool_shdEv", 32'(bus.shieldHitEvent), 1);
    chk("cool_monEv", 32'(bus.monsterHitEvent), 0);
    idle();
    chk("cool_shd_pulse", 32'(bus.shieldHitEvent), 0);
    drive(1'b0, 9, 9, 1'b1, 1'b1, 1'b1, 1'b0); sof_step();
    chk("cool2_shdEv", 32'(bus.shieldHitEvent), 1);
    chk("cool2_monEv", 32'(bus.monsterHitEvent), 0);
    chk("cool2_cnt", 32'(bus.monsterHitCount), 1);

    // overlap on the startOfFrame cycle belongs to the new frame
    drive(1'b1, 77, 88, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sofovl_noEv", 32'(bus.monsterHitEvent), 0);
    sof_step();
    chk("sofovl_ev", 32'(bus.monsterHitEvent), 1);
    chk("sofovl_x", 32'(bus.hitX), 77);
    chk("sofovl_y", 32'(bus.hitY), 88);

    // border hits saturate the 2-bit miss counter
    do_reset();
    for (int f = 0; f < 5; f++) begin
      drive(1'b0, 300, 10, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("bdr_coll", 32'(bus.collisionBorder), 1);
      sof_step();
      chk("bdr_noShd", 32'(bus.shieldHitEvent), 0);
      if (f == 1) chk("bdr_miss2", 32'(bus.missCount), 2);
    end
    chk("bdr_sat", 32'(bus.missCount), 3);
    chk("bdr_collOff", 32'(bus.collisionBorder), 0);

    // reset mid-frame discards pending hit
    do_reset();
    drive(1'b0, 12, 34, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_collM", 32'(bus.collisionMonster), 1);
    resetN = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1 resetN = 1'b1;
    sof_step();
    chk("mid_noEv", 32'(bus.monsterHitEvent), 0);
    chk("mid_cnt", 32'(bus.monsterHitCount), 0);
    drive(1'b0, 15, 16, 1'b1, 1'b1, 1'b0, 1'b0); sof_step();
    chk("mid_armed_ev", 32'(bus.monsterHitEvent), 1);
    chk("mid_armed_x", 32'(bus.hitX), 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
